wub_apb_slot_ctrl: RTL and testbench
====================================

// Module: wub_apb_slot_ctrl
// PURPOSE
//  Fabric-side APB3 controller between the MSS APB master port and N_SLOTS fabric peripheral slots.
//  - Decodes the MSS address, sequences one downstream APB transfer at a time and returns data/status to the MSS.
//  - A per-transfer watchdog turns a hung slot into a PSLVERR response, so the Cortex-M3 never stalls.
// PARAMETERS
//  N_SLOTS       4     number of downstream slots (1..16)
//  SLOT_SEL_LSB  12    LSB of slot index field in MSSPADDR (each slot owns 2^SLOT_SEL_LSB bytes)
//  SLOT_AW       12    width of S_PADDR (offset within slot); must equal SLOT_SEL_LSB
//  TIMEOUT_CYC   256   max S_PENABLE cycles before abort (>=2)
// PORTS
//  FAB_CLK       in   1          fabric clock (MSS FAB_CLK)
//  M2F_RESET_N   in   1          async active-low reset
//  MSSPSEL       in   1          upstream APB select
//  MSSPENABLE    in   1          upstream APB enable
//  MSSPWRITE     in   1          upstream write
//  MSSPADDR      in   32         upstream address
//  MSSPWDATA     in   32         upstream write data
//  MSSPRDATA     out  32         upstream read data
//  MSSPREADY     out  1          upstream ready
//  MSSPSLVERR    out  1          upstream error
//  S_PSEL        out  N_SLOTS    one-hot slot select
//  S_PENABLE     out  1          shared enable
//  S_PWRITE      out  1          shared write
//  S_PADDR       out  SLOT_AW    shared offset address
//  S_PWDATA      out  32         shared write data
//  S_PRDATA      in   32*N_SLOTS slot read data, slot k at [32k+:32]
//  S_PREADY      in   N_SLOTS    slot ready
//  S_PSLVERR     in   N_SLOTS    slot error
// BEHAVIOUR
//  - One clock (FAB_CLK); reset is asynchronous, active-low (M2F_RESET_N). All outputs registered.
//  - Reset values: every output 0; state IDLE; timeout counter 0.
//  - idx = MSSPADDR[SLOT_SEL_LSB +: clog2(N_SLOTS)]; decode error if idx>=N_SLOTS or any MSSPADDR bits above the field are set.
//  - FSM:
//    - IDLE: on MSSPSEL & !MSSPENABLE, capture addr/wdata/write/idx.
//      Decode error -> RESP with err=1, rdata=0. Otherwise -> SETUP with S_PSEL[idx]=1.
//    - SETUP: S_PSEL held, S_PENABLE=1 next -> ACCESS; timeout counter cleared.
//    - ACCESS: sample S_PREADY[idx] each cycle.
//      On 1: capture S_PRDATA slot idx (read only; 0 on write) and S_PSLVERR[idx], drop S_PSEL/S_PENABLE -> RESP.
//      When the counter reaches TIMEOUT_CYC-1 with ready low: abort (drop PSEL/PENABLE), err=1, rdata=32'hDEAD_0BAD -> RESP.
//    - RESP: MSSPREADY=1 for exactly one cycle with MSSPRDATA/MSSPSLVERR valid; next cycle -> IDLE, MSSPREADY/MSSPSLVERR/MSSPRDATA return to 0.
//  - Latency (valid decode, zero-wait slot): MSS setup at cycle 0, S_PSEL cycle 1, S_PENABLE cycle 2, MSSPREADY cycle 4.
//  - Decode error: MSSPREADY at cycle 2.
//  - S_PREADY from non-selected slots, and any S_PREADY outside ACCESS, is ignored.
//  - S_PREADY in the same cycle as timeout expiry: the ready wins (normal completion).
//  - MSSPSEL dropped before RESP (protocol violation): the transfer completes downstream; the RESP pulse is still issued; no hang.
//  - Upstream APB rule: MSSPREADY is never asserted while MSSPENABLE=0.
//    A RESP reached before the MSS enable phase stalls in RESP until MSSPENABLE=1.
//  - Reset mid-transfer: all outputs drop to 0 asynchronously; the slot sees PSEL fall without completion.
//  - S_PADDR = captured MSSPADDR[SLOT_AW-1:0]. S_PWDATA/S_PWRITE/S_PADDR are held stable from SETUP through ACCESS.
// CONFIGURATION
//  WUB_APB_ERRLOG_EN defined: adds outputs ERR_CNT[15:0] and ERR_ADDR[31:0].
//    - ERR_CNT: saturating count of decode errors, timeouts and slot PSLVERR responses, incremented on the RESP cycle; holds at 16'hFFFF.
//    - ERR_ADDR: address of the most recent erroring transfer.
//    - Both reset to 0.
//  Undefined: ports and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package wub_apb_pkg: state enum {IDLE,SETUP,ACCESS,RESP}, TIMEOUT_RDATA constant (32'hDEAD_0BAD), clog2 function.
//  - Sub-module wub_apb_timeout: clear/enable/expired counter of width clog2(TIMEOUT_CYC).
// TESTING
//  - Write 32'h1234_5678 to 0x0000_1004, slot1 ready immediately -> S_PSEL=4'b0010, S_PADDR=12'h004.
//    MSSPREADY at cycle 4, MSSPSLVERR=0.
//  - Read 0x0000_2010, slot2 returns 32'hCAFE_F00D after 3 wait cycles -> MSSPRDATA=32'hCAFE_F00D, MSSPREADY at cycle 7.
//  - Read 0x0000_5000 (idx 5 >= N_SLOTS) -> no S_PSEL.
//    MSSPREADY at cycle 2, MSSPSLVERR=1, MSSPRDATA=0.
//  - Slot0 never ready -> after 256 PENABLE cycles S_PSEL drops and MSSPSLVERR=1 with MSSPRDATA=32'hDEAD_0BAD.
//    The next transfer to slot3 then succeeds.
//  - Slot3 asserts S_PREADY=1 and S_PSLVERR=1 -> MSSPSLVERR=1.
//    With WUB_APB_ERRLOG_EN: ERR_CNT increments, ERR_ADDR=0x0000_3000.
//  - Assert M2F_RESET_N=0 during ACCESS -> all outputs 0 same cycle; after release, an IDLE transfer completes normally.

Source files
------------

// File: rtl/wub_apb_pkg.sv
// Shared types and constants for the fabric APB slot controller.
package wub_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_0BAD;

  // Number of bits needed to hold values 0..v-1 (0 for v<=1).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wub_apb_slot_ctrl_timeout.sv
// Per-transfer watchdog: counts enable-phase cycles, flags the last permitted one.
module wub_apb_timeout
  import wub_apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wub_apb_slot_ctrl.sv
// MSS APB3 to N fabric slot controller with per-transfer watchdog.
// Optional error log (ERR_CNT/ERR_ADDR) enabled by defining WUB_APB_ERRLOG_EN.
module wub_apb_slot_ctrl
  import wub_apb_pkg::*;
#(
  parameter int N_SLOTS      = 4,
  parameter int SLOT_SEL_LSB = 12,
  parameter int SLOT_AW      = 12,
  parameter int TIMEOUT_CYC  = 256
) (
  input  logic                   FAB_CLK,
  input  logic                   M2F_RESET_N,
  input  logic                   MSSPSEL,
  input  logic                   MSSPENABLE,
  input  logic                   MSSPWRITE,
  input  logic [31:0]            MSSPADDR,
  input  logic [31:0]            MSSPWDATA,
  output logic [31:0]            MSSPRDATA,
  output logic                   MSSPREADY,
  output logic                   MSSPSLVERR,
  output logic [N_SLOTS-1:0]     S_PSEL,
  output logic                   S_PENABLE,
  output logic                   S_PWRITE,
  output logic [SLOT_AW-1:0]     S_PADDR,
  output logic [31:0]            S_PWDATA,
  input  logic [32*N_SLOTS-1:0]  S_PRDATA,
  input  logic [N_SLOTS-1:0]     S_PREADY,
  input  logic [N_SLOTS-1:0]     S_PSLVERR
`ifdef WUB_APB_ERRLOG_EN
  ,
  output logic [15:0]            ERR_CNT,
  output logic [31:0]            ERR_ADDR
`endif
);

  localparam int IDX_RAW = clog2(N_SLOTS);
  localparam int IDX_W   = (IDX_RAW == 0) ? 1 : IDX_RAW;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [31:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic [N_SLOTS-1:0]   s_psel_q, s_psel_d;
  logic                 s_penable_q, s_penable_d;
  logic                 s_pwrite_q, s_pwrite_d;
  logic [SLOT_AW-1:0]   s_paddr_q, s_paddr_d;
  logic [31:0]          s_pwdata_q, s_pwdata_d;
  logic [31:0]          mss_rdata_q, mss_rdata_d;
  logic                 mss_ready_q, mss_ready_d;
  logic                 mss_err_q, mss_err_d;
`ifdef WUB_APB_ERRLOG_EN
  logic [31:0]          addr_q, addr_d;
  logic [15:0]          err_cnt_q, err_cnt_d;
  logic [31:0]          err_addr_q, err_addr_d;
`endif

  logic [31:0]          addr_hi;
  logic [IDX_W-1:0]     dec_idx;
  logic                 dec_err;
  logic                 to_expired;
  logic [31:0]          slot_rdata [N_SLOTS];

  for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_slot_rdata
    assign slot_rdata[gi] = S_PRDATA[32*gi +: 32];
  end

  // Anything above the slot index field must be zero for a valid decode.
  assign addr_hi = MSSPADDR >> (SLOT_SEL_LSB + IDX_RAW);
  assign dec_idx = IDX_W'(MSSPADDR >> SLOT_SEL_LSB);
  assign dec_err = (addr_hi != '0) || (32'(dec_idx) >= 32'(N_SLOTS));

  wub_apb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (FAB_CLK),
    .rst_n     (M2F_RESET_N),
    .clr_i     (state_q != ACCESS),
    .en_i      (state_q == ACCESS),
    .expired_o (to_expired)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    s_psel_d     = s_psel_q;
    s_penable_d  = s_penable_q;
    s_pwrite_d   = s_pwrite_q;
    s_paddr_d    = s_paddr_q;
    s_pwdata_d   = s_pwdata_q;
    mss_rdata_d  = '0;
    mss_ready_d  = 1'b0;
    mss_err_d    = 1'b0;
`ifdef WUB_APB_ERRLOG_EN
    addr_d       = addr_q;
    err_cnt_d    = err_cnt_q;
    err_addr_d   = err_addr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (MSSPSEL && !MSSPENABLE) begin
          idx_d = dec_idx;
`ifdef WUB_APB_ERRLOG_EN
          addr_d = MSSPADDR;
`endif
          if (dec_err) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else begin
            s_psel_d   = N_SLOTS'(1) << dec_idx;
            s_pwrite_d = MSSPWRITE;
            s_paddr_d  = MSSPADDR[SLOT_AW-1:0];
            s_pwdata_d = MSSPWDATA;
            state_d    = SETUP;
          end
        end
      end

      SETUP: begin
        s_penable_d = 1'b1;
        state_d     = ACCESS;
      end

      ACCESS: begin
        // Ready is checked before expiry so a last-cycle response still completes.
        if (S_PREADY[idx_q]) begin
          resp_rdata_d = s_pwrite_q ? 32'h0 : slot_rdata[idx_q];
          resp_err_d   = S_PSLVERR[idx_q];
          s_psel_d     = '0;
          s_penable_d  = 1'b0;
          state_d      = RESP;
        end else if (to_expired) begin
          resp_rdata_d = TIMEOUT_RDATA;
          resp_err_d   = 1'b1;
          s_psel_d     = '0;
          s_penable_d  = 1'b0;
          state_d      = RESP;
        end
      end

      RESP: begin
        // Wait for the enable phase; an abandoned transfer (PSEL gone) still retires.
        if (MSSPENABLE || !MSSPSEL) begin
          mss_ready_d = 1'b1;
          mss_rdata_d = resp_rdata_q;
          mss_err_d   = resp_err_q;
          state_d     = IDLE;
`ifdef WUB_APB_ERRLOG_EN
          if (resp_err_q) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            err_addr_d = addr_q;
          end
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      s_psel_q     <= '0;
      s_penable_q  <= 1'b0;
      s_pwrite_q   <= 1'b0;
      s_paddr_q    <= '0;
      s_pwdata_q   <= '0;
      mss_rdata_q  <= '0;
      mss_ready_q  <= 1'b0;
      mss_err_q    <= 1'b0;
`ifdef WUB_APB_ERRLOG_EN
      addr_q       <= '0;
      err_cnt_q    <= '0;
      err_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      s_psel_q     <= s_psel_d;
      s_penable_q  <= s_penable_d;
      s_pwrite_q   <= s_pwrite_d;
      s_paddr_q    <= s_paddr_d;
      s_pwdata_q   <= s_pwdata_d;
      mss_rdata_q  <= mss_rdata_d;
      mss_ready_q  <= mss_ready_d;
      mss_err_q    <= mss_err_d;
`ifdef WUB_APB_ERRLOG_EN
      addr_q       <= addr_d;
      err_cnt_q    <= err_cnt_d;
      err_addr_q   <= err_addr_d;
`endif
    end
  end

  assign MSSPRDATA  = mss_rdata_q;
  assign MSSPREADY  = mss_ready_q;
  assign MSSPSLVERR = mss_err_q;
  assign S_PSEL     = s_psel_q;
  assign S_PENABLE  = s_penable_q;
  assign S_PWRITE   = s_pwrite_q;
  assign S_PADDR    = s_paddr_q;
  assign S_PWDATA   = s_pwdata_q;
`ifdef WUB_APB_ERRLOG_EN
  assign ERR_CNT    = err_cnt_q;
  assign ERR_ADDR   = err_addr_q;
`endif

endmodule

// File: tb/tb_wub_apb_slot_ctrl.sv
// Directed self-checking bench for wub_apb_slot_ctrl (default 4 slots, 256-cycle watchdog).
module tb_wub_apb_slot_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         MSSPSEL = 0, MSSPENABLE = 0, MSSPWRITE = 0;
  logic [31:0]  MSSPADDR = '0, MSSPWDATA = '0;
  logic [31:0]  MSSPRDATA;
  logic         MSSPREADY, MSSPSLVERR;
  logic [3:0]   S_PSEL;
  logic         S_PENABLE, S_PWRITE;
  logic [11:0]  S_PADDR;
  logic [31:0]  S_PWDATA;
  logic [127:0] S_PRDATA;
  logic [3:0]   S_PREADY = '0, S_PSLVERR = '0;
`ifdef WUB_APB_ERRLOG_EN
  logic [15:0]  ERR_CNT;
  logic [31:0]  ERR_ADDR;
`endif

  always #5 clk = ~clk;

  wub_apb_slot_ctrl dut (
    .FAB_CLK(clk), .M2F_RESET_N(rst_n),
    .MSSPSEL(MSSPSEL), .MSSPENABLE(MSSPENABLE), .MSSPWRITE(MSSPWRITE),
    .MSSPADDR(MSSPADDR), .MSSPWDATA(MSSPWDATA), .MSSPRDATA(MSSPRDATA),
    .MSSPREADY(MSSPREADY), .MSSPSLVERR(MSSPSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE),
    .S_PADDR(S_PADDR), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR)
`ifdef WUB_APB_ERRLOG_EN
    , .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Slot behaviour for the current test.
  int         cfg_wait [4];
  logic [3:0] cfg_err;
  logic [3:0] cfg_noise;
  bit         cfg_early;

  // Observations from the last transfer (cycle 0 = MSS setup cycle).
  int          r_ready_cyc, r_pen_cnt, r_last_psel_cyc;
  bit          r_any_psel;
  logic [31:0] r_rdata, r_pwdata1;
  logic        r_err, r_pwrite1;
  logic [3:0]  r_psel1;
  logic [11:0] r_paddr1;

  task automatic set_cfg(input int w0, input int w1, input int w2, input int w3,
                         input logic [3:0] err, input logic [3:0] noise, input bit early);
    cfg_wait[0] = w0; cfg_wait[1] = w1; cfg_wait[2] = w2; cfg_wait[3] = w3;
    cfg_err = err; cfg_noise = noise; cfg_early = early;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    int acc;
    logic [3:0] rdy_v, err_v;
    acc = 0; r_ready_cyc = -1; r_pen_cnt = 0; r_last_psel_cyc = -1; r_any_psel = 0;
    r_rdata = 'x; r_err = 1'bx;
    @(posedge clk); #1;
    MSSPSEL = 1; MSSPENABLE = 0; MSSPWRITE = wr; MSSPADDR = addr; MSSPWDATA = wdata;
    S_PREADY = cfg_noise; S_PSLVERR = cfg_noise;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      MSSPENABLE = 1;
      if (c == 1) begin
        r_psel1 = S_PSEL; r_paddr1 = S_PADDR; r_pwdata1 = S_PWDATA; r_pwrite1 = S_PWRITE;
      end
      if (S_PSEL != 4'b0) begin r_any_psel = 1; r_last_psel_cyc = c; end
      if (S_PENABLE) r_pen_cnt++;
      if (MSSPREADY) begin
        r_ready_cyc = c; r_rdata = MSSPRDATA; r_err = MSSPSLVERR;
        break;
      end
      rdy_v = cfg_noise & ~S_PSEL;
      err_v = cfg_noise & ~S_PSEL;
      for (int k = 0; k < 4; k++) begin
        if (S_PSEL[k]) begin
          if (S_PENABLE && acc == cfg_wait[k]) begin
            rdy_v[k] = 1'b1; err_v[k] = cfg_err[k];
          end else if (!S_PENABLE && cfg_early) begin
            rdy_v[k] = 1'b1;
          end
        end
      end
      if (S_PENABLE) acc++;
      S_PREADY = rdy_v; S_PSLVERR = err_v;
    end
    MSSPSEL = 0; MSSPENABLE = 0; S_PREADY = '0; S_PSLVERR = '0;
    checks++;
    if (r_ready_cyc < 0) begin
      errors++;
      $display("FAIL xfer_no_ready addr=%h: got no MSSPREADY within 400 cycles, required a response", addr);
    end else begin
      @(posedge clk); #1;
      if (MSSPREADY !== 1'b0 || MSSPSLVERR !== 1'b0 || MSSPRDATA !== 32'h0) begin
        errors++;
        $display("FAIL resp_clear addr=%h: got ready=%b err=%b rdata=%h, required 0/0/0",
                 addr, MSSPREADY, MSSPSLVERR, MSSPRDATA);
      end
    end
    $display("xfer %s addr=%h ready_cyc=%0d rdata=%h err=%b", wr ? "WR" : "RD", addr,
             r_ready_cyc, r_rdata, r_err);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({MSSPRDATA, MSSPREADY, MSSPSLVERR, S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b psel=%b pen=%b, required all 0",
               MSSPRDATA, MSSPREADY, MSSPSLVERR, S_PSEL, S_PENABLE);
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_write();
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 0);
    xfer(1'b1, 32'h0000_1004, 32'h1234_5678);
    checks++; if (r_psel1 !== 4'b0010) begin errors++; $display("FAIL wr_psel got=%b exp=0010", r_psel1); end
    checks++; if (r_paddr1 !== 12'h004) begin errors++; $display("FAIL wr_paddr got=%h exp=004", r_paddr1); end
    checks++; if (r_pwdata1 !== 32'h1234_5678 || r_pwrite1 !== 1'b1) begin
      errors++; $display("FAIL wr_pwdata got=%h/%b exp=12345678/1", r_pwdata1, r_pwrite1); end
    checks++; if (r_ready_cyc !== 4) begin errors++; $display("FAIL wr_ready_cyc got=%0d exp=4", r_ready_cyc); end
    checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL wr_resp got err=%b rdata=%h exp 0/0", r_err, r_rdata); end
  endtask

  task automatic test_read_wait();
    set_cfg(0, 0, 3, 0, 4'b0, 4'b1011, 0);   // other slots spam ready/err
    xfer(1'b0, 32'h0000_2010, 32'h0);
    checks++; if (r_psel1 !== 4'b0100 || r_paddr1 !== 12'h010 || r_pwrite1 !== 1'b0) begin
      errors++; $display("FAIL rd_setup got psel=%b paddr=%h pwrite=%b exp 0100/010/0", r_psel1, r_paddr1, r_pwrite1); end
    checks++; if (r_ready_cyc !== 7) begin errors++; $display("FAIL rd_ready_cyc got=%0d exp=7", r_ready_cyc); end
    checks++; if (r_rdata !== 32'hCAFE_F00D || r_err !== 1'b0) begin
      errors++; $display("FAIL rd_data got=%h err=%b exp CAFEF00D/0", r_rdata, r_err); end
  endtask

  task automatic test_early_ready();
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 1);
    xfer(1'b0, 32'h0000_1000, 32'h0);
    checks++; if (r_ready_cyc !== 4 || r_rdata !== 32'h1111_1111) begin
      errors++; $display("FAIL early_ready got cyc=%0d rdata=%h exp 4/11111111", r_ready_cyc, r_rdata); end
  endtask

  task automatic test_decode_err();
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 0);
    xfer(1'b0, 32'h0000_5000, 32'h0);
    checks++; if (r_any_psel !== 1'b0) begin errors++; $display("FAIL dec_psel got psel activity, exp none"); end
    checks++; if (r_ready_cyc !== 2) begin errors++; $display("FAIL dec_ready_cyc got=%0d exp=2", r_ready_cyc); end
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL dec_resp got err=%b rdata=%h exp 1/0", r_err, r_rdata); end
    xfer(1'b1, 32'h1000_1000, 32'h55);
    checks++; if (r_any_psel !== 1'b0 || r_ready_cyc !== 2 || r_err !== 1'b1) begin
      errors++; $display("FAIL dec_high got psel=%b cyc=%0d err=%b exp 0/2/1", r_any_psel, r_ready_cyc, r_err); end
  endtask

  task automatic test_timeout();
    set_cfg(1000, 0, 0, 0, 4'b0, 4'b0, 0);
    xfer(1'b0, 32'h0000_0040, 32'h0);
    checks++; if (r_pen_cnt !== 256 || r_last_psel_cyc !== 257) begin
      errors++; $display("FAIL to_span got pen_cycles=%0d last_psel=%0d exp 256/257", r_pen_cnt, r_last_psel_cyc); end
    checks++; if (r_ready_cyc !== 259) begin errors++; $display("FAIL to_ready_cyc got=%0d exp=259", r_ready_cyc); end
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'hDEAD_0BAD) begin
      errors++; $display("FAIL to_resp got err=%b rdata=%h exp 1/DEAD0BAD", r_err, r_rdata); end
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 0);
    xfer(1'b0, 32'h0000_3000, 32'h0);
    checks++; if (r_ready_cyc !== 4 || r_rdata !== 32'h3333_3333 || r_err !== 1'b0) begin
      errors++; $display("FAIL after_to got cyc=%0d rdata=%h err=%b exp 4/33333333/0", r_ready_cyc, r_rdata, r_err); end
    set_cfg(255, 0, 0, 0, 4'b0, 4'b0, 0);    // ready on the expiry cycle
    xfer(1'b0, 32'h0000_0000, 32'h0);
    checks++; if (r_ready_cyc !== 259 || r_rdata !== 32'hA0A0_0000 || r_err !== 1'b0) begin
      errors++; $display("FAIL to_race got cyc=%0d rdata=%h err=%b exp 259/A0A00000/0", r_ready_cyc, r_rdata, r_err); end
  endtask

  task automatic test_slverr();
    set_cfg(0, 0, 0, 0, 4'b1000, 4'b0, 0);
    xfer(1'b1, 32'h0000_3000, 32'hABCD_0001);
    checks++; if (r_ready_cyc !== 4 || r_err !== 1'b1) begin
      errors++; $display("FAIL slverr got cyc=%0d err=%b exp 4/1", r_ready_cyc, r_err); end
`ifdef WUB_APB_ERRLOG_EN
    checks++; if (ERR_CNT !== 16'd4 || ERR_ADDR !== 32'h0000_3000) begin
      errors++; $display("FAIL errlog got cnt=%0d addr=%h exp 4/00003000", ERR_CNT, ERR_ADDR); end
`endif
  endtask

  task automatic test_reset_mid();
    set_cfg(0, 1000, 0, 0, 4'b0, 4'b0, 0);
    @(posedge clk); #1;
    MSSPSEL = 1; MSSPENABLE = 0; MSSPWRITE = 1; MSSPADDR = 32'h0000_1008; MSSPWDATA = 32'hFFFF_0000;
    @(posedge clk); #1; MSSPENABLE = 1;
    @(posedge clk); #1;
    checks++; if (S_PENABLE !== 1'b1 || S_PSEL !== 4'b0010) begin
      errors++; $display("FAIL rstmid_access got pen=%b psel=%b exp 1/0010", S_PENABLE, S_PSEL); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({MSSPRDATA, MSSPREADY, MSSPSLVERR, S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h, exp all 0",
               S_PSEL, S_PENABLE, S_PWRITE, S_PADDR, S_PWDATA);
    end
    MSSPSEL = 0; MSSPENABLE = 0;
    @(negedge clk); rst_n = 1;
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 0);
    xfer(1'b0, 32'h0000_1000, 32'h0);
    checks++; if (r_ready_cyc !== 4 || r_rdata !== 32'h1111_1111 || r_err !== 1'b0) begin
      errors++; $display("FAIL rstmid_after got cyc=%0d rdata=%h err=%b exp 4/11111111/0", r_ready_cyc, r_rdata, r_err); end
  endtask

  task automatic test_back_to_back();
    set_cfg(0, 0, 0, 1, 4'b0, 4'b0, 0);
    xfer(1'b1, 32'h0000_0FFC, 32'h0BAD_F00D);
    checks++; if (r_psel1 !== 4'b0001 || r_paddr1 !== 12'hFFC || r_ready_cyc !== 4) begin
      errors++; $display("FAIL b2b_first got psel=%b paddr=%h cyc=%0d exp 0001/FFC/4", r_psel1, r_paddr1, r_ready_cyc); end
    xfer(1'b0, 32'h0000_3FF0, 32'h0);
    checks++; if (r_psel1 !== 4'b1000 || r_ready_cyc !== 5 || r_rdata !== 32'h3333_3333) begin
      errors++; $display("FAIL b2b_second got psel=%b cyc=%0d rdata=%h exp 1000/5/33333333", r_psel1, r_ready_cyc, r_rdata); end
  endtask

  initial begin
    S_PRDATA = {32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111, 32'hA0A0_0000};
    set_cfg(0, 0, 0, 0, 4'b0, 4'b0, 0);
    test_reset();
    test_write();
    test_read_wait();
    test_early_ready();
    test_decode_err();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
